// File: rtl/universal_register.sv
// Multi-mode datapath register: hold/load/shift/rotate/inc/dec with registered carry and zero flag.
// Latency: one clock from operation sample to q/carry update; zero is combinational on q.
// Backpressure: none; accepts one operation every cycle, en low simply holds state.
module universal_register #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             carry,
    output logic             zero
);

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_nxt;
    logic             carry_nxt;
    logic [WIDTH:0]   inc_sum;
    logic [WIDTH-1:0] dec_diff;

    // Widened increment exposes the wrap from all-ones as the top bit;
    // decrement borrows exactly when the old value is zero.
    assign inc_sum  = {1'b0, q} + {1'b0, ONE};
    assign dec_diff = q - ONE;

    // Next-state selection for an enabled operation; carry is never an input here.
    always_comb begin
        q_nxt     = q;
        carry_nxt = carry;
        case (mode_e'(mode))
            M_HOLD: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
            M_LOAD: begin
                q_nxt     = d;
                carry_nxt = 1'b0;
            end
            M_SHL: begin
                q_nxt     = {q[WIDTH-2:0], ser_in};
                carry_nxt = q[WIDTH-1];
            end
            M_SHR: begin
                q_nxt     = {ser_in, q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            M_ROL: begin
                q_nxt     = {q[WIDTH-2:0], q[WIDTH-1]};
                carry_nxt = q[WIDTH-1];
            end
            M_ROR: begin
                q_nxt     = {q[0], q[WIDTH-1:1]};
                carry_nxt = q[0];
            end
            M_INC: begin
                q_nxt     = inc_sum[WIDTH-1:0];
                carry_nxt = inc_sum[WIDTH];
            end
            M_DEC: begin
                q_nxt     = dec_diff;
                carry_nxt = (q == '0);
            end
            default: begin
                q_nxt     = q;
                carry_nxt = carry;
            end
        endcase
    end

    // State register: async reset, then synchronous clear, then enable-gated update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q     <= RESET_VAL;
            carry <= 1'b0;
        end else if (clr) begin
            q     <= '0;
            carry <= 1'b0;
        end else if (en) begin
            q     <= q_nxt;
            carry <= carry_nxt;
        end
    end

    // Zero flag reflects only the current register contents.
    assign zero = (q == '0);

endmodule
